// File: rtl/full_subtractor_st.sv
// Registered single-bit full subtractor (a - b - c) built from two gate-level half subtractors.
// Optional macro FS_SELF_CHECK_EN adds a registered chk_err output comparing against a behavioural reference.
module full_subtractor_st (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   input  logic c,
   output logic difference,
   output logic borrow
`ifdef FS_SELF_CHECK_EN
   ,
   output logic chk_err
`endif
);

   wire na;
   wire d1;
   wire b1;
   wire nd1;
   wire d2;
   wire b2;
   wire borrow_c;

   // First half subtractor handles a - b, second folds in the borrow-in
   not u_na  (na, a);
   xor u_d1  (d1, a, b);
   and u_b1  (b1, na, b);

   not u_nd1 (nd1, d1);
   xor u_d2  (d2, d1, c);
   and u_b2  (b2, nd1, c);

   or  u_bo  (borrow_c, b1, b2);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         difference <= 1'b0;
         borrow     <= 1'b0;
      end else begin
         difference <= d2;
         borrow     <= borrow_c;
      end
   end

`ifdef FS_SELF_CHECK_EN
   logic [1:0] ref_val;

   // Two-bit wraparound of a - b - c yields {borrow, difference} directly
   always_comb begin
      ref_val = {1'b0, a} - {1'b0, b} - {1'b0, c};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         chk_err <= 1'b0;
      end else begin
         chk_err <= (ref_val != {borrow_c, d2});
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n && chk_err) begin
         $error("full_subtractor_st: structural result disagrees with reference");
      end
   end
`endif
`endif

endmodule

// File: tb/tb_full_subtractor_st.sv
// Scoreboard bench for full_subtractor_st: stimulus pushes hand-computed results into a queue,
// a monitor pops one entry after every rising edge and compares the registered outputs.
module tb_full_subtractor_st;

   logic clk = 1'b0;
   logic rst_n;
   logic a;
   logic b;
   logic c;
   logic difference;
   logic borrow;
`ifdef FS_SELF_CHECK_EN
   logic chk_err;
`endif

   logic [1:0] expQ[$];
   logic [1:0] truthTable [8];
   int checks = 0;
   int errors = 0;
   logic stimDone = 1'b0;

   full_subtractor_st dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .b          (b),
      .c          (c),
      .difference (difference),
      .borrow     (borrow)
`ifdef FS_SELF_CHECK_EN
      ,
      .chk_err    (chk_err)
`endif
   );

   always #5 clk = ~clk;

   // Drive one vector at the falling edge and record the {diff,borrow} due after the next rising edge
   task automatic applyStimulus(input logic rstIn, input logic [2:0] abc, input logic [1:0] expDB);
      @(negedge clk);
      rst_n = rstIn;
      {a, b, c} = abc;
      expQ.push_back(expDB);
   endtask

   task automatic checkOutput(input logic [1:0] expDB);
      checks++;
      if ({difference, borrow} !== expDB) begin
         errors++;
         $display("[TB] FAIL dataOut: got diff=%b borrow=%b expected diff=%b borrow=%b at %0t",
                  difference, borrow, expDB[1], expDB[0], $time);
      end
`ifdef FS_SELF_CHECK_EN
      checks++;
      if (chk_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL chkErr: got %b expected 0 at %0t", chk_err, $time);
      end
`endif
   endtask

   // Monitor: every rising edge presents a fresh registered result
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
         end
      end
   end

   initial begin
      // {diff,borrow} indexed by {a,b,c}
      truthTable[0] = 2'b00;
      truthTable[1] = 2'b11;
      truthTable[2] = 2'b11;
      truthTable[3] = 2'b01;
      truthTable[4] = 2'b10;
      truthTable[5] = 2'b00;
      truthTable[6] = 2'b00;
      truthTable[7] = 2'b11;

      rst_n = 1'b0;
      {a, b, c} = 3'b111;

      // Reset held with all inputs high must keep outputs at zero
      applyStimulus(1'b0, 3'b111, 2'b00);
      applyStimulus(1'b0, 3'b111, 2'b00);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 3'(i), truthTable[i]);
      end

      // Reset asserted alongside 011 discards that result
      applyStimulus(1'b1, 3'b000, 2'b00);
      applyStimulus(1'b0, 3'b011, 2'b00);
      applyStimulus(1'b1, 3'b011, 2'b01);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 3'b100, 2'b10);
         applyStimulus(1'b1, 3'b111, 2'b11);
      end

      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 3'b101, 2'b00);
      end

      for (int i = 0; i < 300; i++) begin
         logic [2:0] v;
         v = 3'($urandom_range(0, 7));
         applyStimulus(1'b1, v, truthTable[v]);
      end

      stimDone = 1'b1;
   end

   initial begin
      wait (stimDone);
      for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d results outstanding, expected 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: stimulus did not complete, expected completion before 100000");
      $fatal(1, "[TB] timeout");
   end

endmodule
